// File: rtl/button_event_controller.sv
// ---------------------------------------------------------------------------
// button_event_controller
//
// Front-panel push-button controller. Every channel is synchronized,
// debounced and classified into short, long and auto-repeat events. Two
// channels also drive a small controller:
//   - CMD_BTN  : a long press commits the switch word; a short or long press
//                returns the display mode to 0.
//   - MODE_BTN : a short press or an auto-repeat pulse advances the display
//                mode, wrapping at NUM_MODES.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   btn           in   [NUM_BTN]  raw button pins, active-high
//   sw            in   [DATA_W]   raw switch word, sampled on commit only
//   btn_level     out  [NUM_BTN]  debounced levels
//   short_evt     out  [NUM_BTN]  one-cycle short-press pulses
//   long_evt      out  [NUM_BTN]  one-cycle long-press pulses
//   repeat_evt    out  [NUM_BTN]  one-cycle auto-repeat pulses
//   latched_value out  [DATA_W]   last committed switch word
//   latch_strobe  out             high in the first cycle of a new latched_value
//   display_mode  out  [MODE_W]   current mode, 0 .. NUM_MODES-1
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// button_channel
//
// One button lane: 2-flop synchronizer, debounce counter, hold counter and
// an IDLE/HELD/LONG classifier with registered event pulses.
//
// Ports
//   clk, reset   clock and asynchronous active-low reset
//   btn          raw pin
//   level        debounced level
//   short_evt    released before LONG_CYC high cycles
//   long_evt     LONG_CYC-th consecutive high cycle reached
//   repeat_evt   every REPEAT_CYC high cycles after the long press
// ---------------------------------------------------------------------------
module button_channel #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 100_000_000,
   parameter int REPEAT_CYC   = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic short_evt,
   output logic long_evt,
   output logic repeat_evt
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC);
   // The IDLE cycle that sees the rising level is already high cycle 1 and
   // the hold counter starts at 0 on the first HELD cycle, so HELD fires the
   // long event when the counter holds LONG_CYC-2.
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 2);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_LONG = 2'd2
   } state_t;

   logic [1:0]        sync;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold;
   state_t            state;

   // Debounce: count consecutive cycles where the synchronized pin differs
   // from the current level. The toggle happens on the edge after the count
   // reaches DEBOUNCE_CYC, so a disagreement must last DEBOUNCE_CYC+1 cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync   <= '0;
         db_cnt <= '0;
         level  <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         if (sync[1] == level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Press classifier. Pulses default low so each one lasts a single cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         hold       <= '0;
         short_evt  <= 1'b0;
         long_evt   <= 1'b0;
         repeat_evt <= 1'b0;
      end else begin
         short_evt  <= 1'b0;
         long_evt   <= 1'b0;
         repeat_evt <= 1'b0;
         case (state)
            S_IDLE: begin
               if (level) begin
                  state <= S_HELD;
                  hold  <= '0;
               end
            end
            S_HELD: begin
               if (!level) begin
                  short_evt <= 1'b1;
                  state     <= S_IDLE;
               end else if (hold == LONG_LAST) begin
                  long_evt <= 1'b1;
                  state    <= S_LONG;
                  hold     <= '0;
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            S_LONG: begin
               if (!level) begin
                  state <= S_IDLE;
               end else if (REPEAT_CYC > 0) begin
                  if (hold == REP_LAST) begin
                     repeat_evt <= 1'b1;
                     hold       <= '0;
                  end else begin
                     hold <= hold + 1'b1;
                  end
               end
               // With repeat disabled the counter simply parks at 0.
            end
            default: begin
               state <= S_IDLE;
               hold  <= '0;
            end
         endcase
      end
   end

endmodule

module button_event_controller #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int NUM_BTN      = 5,
   parameter int DATA_W       = 16,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 100_000_000,
   parameter int REPEAT_CYC   = 25_000_000,
   parameter int NUM_MODES    = 3,
   parameter int MODE_W       = 2,
   parameter int CMD_BTN      = 0,
   parameter int MODE_BTN     = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   input  logic [DATA_W-1:0]  sw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] short_evt,
   output logic [NUM_BTN-1:0] long_evt,
   output logic [NUM_BTN-1:0] repeat_evt,
   output logic [DATA_W-1:0]  latched_value,
   output logic               latch_strobe,
   output logic [MODE_W-1:0]  display_mode
);

   localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

   // An out-of-range parameter set elaborates this empty scope, which makes
   // it easy to spot in the elaborated hierarchy.
   generate
      if (CLK_FREQ < 1 || NUM_BTN < 2 || DEBOUNCE_CYC < 1 || LONG_CYC < 2 ||
          REPEAT_CYC < 0 || NUM_MODES < 2 || NUM_MODES > (1 << MODE_W) ||
          CMD_BTN == MODE_BTN || CMD_BTN >= NUM_BTN || MODE_BTN >= NUM_BTN) begin : g_bad_config
      end
   endgenerate

   // One independent lane per button; vector ports are split bit-per-instance.
   button_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
   ) u_ch [NUM_BTN-1:0] (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .level      (btn_level),
      .short_evt  (short_evt),
      .long_evt   (long_evt),
      .repeat_evt (repeat_evt)
   );

   logic commit;
   logic mode_adv;
   logic mode_clr;

   assign commit   = long_evt[CMD_BTN];
   assign mode_adv = short_evt[MODE_BTN] | repeat_evt[MODE_BTN];
   assign mode_clr = short_evt[CMD_BTN]  | long_evt[CMD_BTN];

   // Controller. Advance has priority over clear; a commit in the same cycle
   // still lands because the value path is independent of the mode path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latched_value <= '0;
         latch_strobe  <= 1'b0;
         display_mode  <= '0;
      end else begin
         latch_strobe <= 1'b0;
         if (commit) begin
            latched_value <= sw;
            latch_strobe  <= 1'b1;
         end
         if (mode_adv) begin
            display_mode <= (display_mode == MODE_LAST) ? '0 : display_mode + 1'b1;
         end else if (mode_clr) begin
            display_mode <= '0;
         end
      end
   end

endmodule

// File: doc/button_event_controller.md
# button_event_controller

Parametrised successor to the two-button front-panel controller. Debounces and classifies NUM_BTN push-buttons into short, long and auto-repeat events. Uses two designated channels to latch a DATA_W-bit switch word and to cycle a NUM_MODES-way display mode. Sits between the board pins and the display/formatting path, and exposes per-channel events for other consumers.

## Interface
- CLK_FREQ, 100_000_000: system clock in Hz; informational only, all timing below is given in cycles.
- NUM_BTN, 5: number of button channels, 2 or more.
- DATA_W, 16: width of the switch word and the latched value.
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required before the debounced level changes; 1 or more.
- LONG_CYC, 100_000_000: press length, in cycles, that qualifies as a long press; must exceed 1.
- REPEAT_CYC, 25_000_000: auto-repeat period after a long press; 0 disables repeat.
- NUM_MODES, 3: number of display modes; 2 ≤ NUM_MODES ≤ 2^MODE_W.
- MODE_W, 2: width of display_mode.
- CMD_BTN, 0: channel index of the commit button.
- MODE_BTN, 1: channel index of the mode button; must differ from CMD_BTN, and both must be less than NUM_BTN.
- clk, input, 1: single system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn, input, NUM_BTN: raw, asynchronous button pins, active-high.
- sw, input, DATA_W: raw switch word, sampled only when a latch occurs.
- btn_level, output, NUM_BTN: debounced button levels.
- short_evt, output, NUM_BTN: one-cycle short-press pulse per channel.
- long_evt, output, NUM_BTN: one-cycle long-press pulse per channel.
- repeat_evt, output, NUM_BTN: one-cycle auto-repeat pulse per channel.
- latched_value, output, DATA_W: last committed switch word.
- latch_strobe, output, 1: one-cycle pulse, high in the first cycle a newly written latched_value is visible.
- display_mode, output, MODE_W: current mode, in the range 0 to NUM_MODES-1.

## Operation
- Each channel has a two-flop synchronizer, a debounce counter, a hold counter and a three-state FSM (IDLE, HELD, LONG).
- Debounce:
  - The counter runs while the synchronized input differs from btn_level, and clears whenever they are equal.
  - btn_level toggles when the counter reaches DEBOUNCE_CYC; the counter then clears.
- IDLE to HELD on a btn_level rise; the hold counter is cleared.
- In HELD, the hold counter increments once per cycle while btn_level is 1.
- Define D as the number of cycles btn_level was 1 during the press.
- If btn_level falls while in HELD (D < LONG_CYC):
  - short_evt pulses.
  - The FSM returns to IDLE.
- When D reaches LONG_CYC while in HELD:
  - long_evt pulses exactly once.
  - The FSM moves to LONG and the hold counter restarts at 0.
- In LONG (with REPEAT_CYC > 0), repeat_evt pulses each time the counter reaches REPEAT_CYC; the counter then restarts.
- A fall while in LONG returns the FSM to IDLE with no short_evt.
- Channels are fully independent of each other.
- Commit: long_evt[CMD_BTN] writes latched_value <= sw, taking the sw value sampled in that same cycle.
- Mode advance: short_evt[MODE_BTN] or repeat_evt[MODE_BTN] sets display_mode <= display_mode+1, wrapping from NUM_MODES-1 to 0.
- Mode reset: short_evt[CMD_BTN] or long_evt[CMD_BTN] sets display_mode <= 0.
- Simultaneous advance and reset in the same cycle: the advance wins. A latch triggered in that cycle still occurs.
- Repeat pulses on CMD_BTN have no controller effect.

## Timing
- Reset (asynchronous assert): every flop clears.
  - All outputs are 0, including latched_value = 0 and display_mode = 0.
  - All FSMs go to IDLE.
- Reset mid-press: the press is discarded. A button still held at reset release is treated as a new press after debounce.
- Debounce latency: btn_level rises DEBOUNCE_CYC+2 edges after the first rising edge that samples a clean high on btn. The fall has the same latency.
- Event outputs are registered:
  - short_evt is high in the cycle after the first cycle with btn_level = 0.
  - long_evt is high in the cycle after the LONG_CYC-th high cycle.
  - The k-th repeat_evt follows LONG_CYC + k·REPEAT_CYC high cycles.
- Controller latency: latched_value, latch_strobe and display_mode update one edge after the causing event pulse.
- Glitches shorter than DEBOUNCE_CYC cycles at the synchronizer output produce no level change and no events.
- Counters saturate or clear as specified; no wrap-around is permitted in any counter.

## Test plan
All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, NUM_MODES=3.

- Glitch: pulse btn[1] high for 3 cycles -> btn_level stays 0, no events, display_mode stays 0.
- Short press: hold btn[1] for 10 debounced cycles, three times -> three short_evt[1] pulses; display_mode steps 1, 2, 0 (wrap).
- Long press and commit: set sw=16'hA5C3, hold btn[0] for 30 cycles -> one long_evt[0], latched_value=16'hA5C3 with latch_strobe high for one cycle, display_mode=0, no short_evt[0] on release.
- Repeat: with display_mode=0, hold btn[1] for 45 high cycles -> long_evt[1] after cycle 20, repeat_evt[1] after cycles 28, 36 and 44, display_mode=0 at the end (three advances).
- Simultaneous events: release btn[0] (short) and btn[1] (short) on the same debounced cycle with mode=1 -> display_mode=2.
- Reset mid-press: assert reset at cycle 15 of a btn[0] hold with sw=16'h1234 -> all outputs 0; after release, no long_evt until 20 new high cycles following re-debounce; latched_value stays 0 until then.
